// File: rtl/surv_mem_ctrl_pkg.sv
// Shared constants and FSM encoding for the Viterbi survivor-memory scheduler.
package surv_mem_ctrl_pkg;

   localparam int N_ACS         = 8;
   localparam int WD_RAM_DATA   = 2 * N_ACS;
   localparam int WD_RAM_ADDR   = 8;
   localparam int TB_DEPTH_DEF  = 16;
   localparam int TB_STRIDE_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } surv_state_t;

endpackage

// File: rtl/surv_mem_ctrl_ram_arb.sv
// Single-port survivor RAM arbiter: buffered writes always win over traceback reads,
// and the winner's address is registered onto RamAddr.
module surv_ram_arb
   import surv_mem_ctrl_pkg::*;
#(
   parameter int WD_RAM_ADDR = surv_mem_ctrl_pkg::WD_RAM_ADDR
) (
   input  logic                   Clock1,
   input  logic                   Reset,
   input  logic                   wr_req,
   input  logic [WD_RAM_ADDR-1:0] wr_addr,
   input  logic                   rd_req,
   input  logic [WD_RAM_ADDR-1:0] rd_addr,
   output logic                   RamWE,
   output logic [WD_RAM_ADDR-1:0] RamAddr,
   output logic                   TBRdGnt
);

   // A read that loses to a write simply stays requested; writes never come
   // two cycles in a row, so it is served on the following cycle.
   always_ff @(posedge Clock1 or negedge Reset) begin
      if (!Reset) begin
         RamWE   <= 1'b0;
         TBRdGnt <= 1'b0;
         RamAddr <= '0;
      end else if (wr_req) begin
         RamWE   <= 1'b1;
         TBRdGnt <= 1'b0;
         RamAddr <= wr_addr;
      end else if (rd_req) begin
         RamWE   <= 1'b0;
         TBRdGnt <= 1'b1;
         RamAddr <= rd_addr;
      end else begin
         RamWE   <= 1'b0;
         TBRdGnt <= 1'b0;
      end
   end

endmodule

// File: rtl/surv_mem_ctrl.sv
// Survivor memory write/traceback scheduler for the Viterbi decoder.
// Optional macro SURV_FLUSH_EN: issue a final traceback when Active falls.
module surv_mem_ctrl
   import surv_mem_ctrl_pkg::*;
#(
   parameter int WD_RAM_ADDR = surv_mem_ctrl_pkg::WD_RAM_ADDR,
   parameter int RAM_DEPTH   = 2 ** WD_RAM_ADDR,
   parameter int TB_DEPTH    = TB_DEPTH_DEF,
   parameter int TB_STRIDE   = TB_STRIDE_DEF
) (
   input  logic                   Clock1,
   input  logic                   Reset,
   input  logic                   Active,
   input  logic                   SurvValid,
   output logic                   SurvRDY,
   output logic                   RamWE,
   output logic [WD_RAM_ADDR-1:0] RamAddr,
   input  logic                   TBRdReq,
   input  logic [WD_RAM_ADDR-1:0] TBRdAddr,
   output logic                   TBRdGnt,
   output logic                   TBStart,
   output logic [WD_RAM_ADDR-1:0] TBStartAddr
);

   localparam int WD_FILL   = $clog2(TB_DEPTH + 1);
   localparam int WD_STRIDE = $clog2(TB_STRIDE + 1);

   surv_state_t            state, next_state;
   logic                   phase;
   logic [WD_RAM_ADDR-1:0] wr_ptr;
   logic [WD_FILL-1:0]     fill_cnt;
   logic [WD_STRIDE-1:0]   stride_cnt;
   logic                   fill_hit, stride_hit, launch;
   logic [WD_RAM_ADDR-1:0] launch_addr;

   assign SurvRDY    = SurvValid && phase && (state != ST_IDLE);
   assign fill_hit   = (state == ST_FILL) && RamWE && (fill_cnt == WD_FILL'(TB_DEPTH - 1));
   assign stride_hit = (state == ST_RUN) && RamWE && (stride_cnt == WD_STRIDE'(TB_STRIDE - 1));

   always_ff @(posedge Clock1 or negedge Reset) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (Active) next_state = ST_FILL;
         ST_FILL: if (fill_cnt == WD_FILL'(TB_DEPTH)) next_state = ST_RUN;
         ST_RUN:  next_state = ST_RUN;
         default: next_state = ST_IDLE;
      endcase
      if (!Active) next_state = ST_IDLE;
   end

   // Dropping Active restarts pairing and pointers from scratch; a write already
   // registered in the arbiter still completes on the RAM.
   always_ff @(posedge Clock1 or negedge Reset) begin
      if (!Reset) begin
         phase      <= 1'b0;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         stride_cnt <= '0;
      end else if (!Active) begin
         phase      <= 1'b0;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         stride_cnt <= '0;
      end else begin
         if (SurvValid && (state != ST_IDLE)) phase <= ~phase;
         if (RamWE) begin
            wr_ptr <= (wr_ptr == WD_RAM_ADDR'(RAM_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (fill_cnt != WD_FILL'(TB_DEPTH)) fill_cnt <= fill_cnt + 1'b1;
            if (state == ST_RUN) stride_cnt <= stride_hit ? '0 : stride_cnt + 1'b1;
         end
      end
   end

   // The address being written this cycle is the one a launched traceback starts from.
   always_comb begin
      launch      = Active && (fill_hit || stride_hit);
      launch_addr = RamAddr;
`ifdef SURV_FLUSH_EN
      if (!Active && (state != ST_IDLE) && (RamWE || (fill_cnt != '0))) begin
         launch      = 1'b1;
         launch_addr = RamWE ? RamAddr : wr_ptr - 1'b1;
      end
`endif
   end

   always_ff @(posedge Clock1 or negedge Reset) begin
      if (!Reset) begin
         TBStart     <= 1'b0;
         TBStartAddr <= '0;
      end else begin
         TBStart <= launch;
         if (launch) TBStartAddr <= launch_addr;
      end
   end

   surv_ram_arb #(
      .WD_RAM_ADDR (WD_RAM_ADDR)
   ) u_arb (
      .Clock1  (Clock1),
      .Reset   (Reset),
      .wr_req  (SurvRDY),
      .wr_addr (wr_ptr),
      .rd_req  (TBRdReq),
      .rd_addr (TBRdAddr),
      .RamWE   (RamWE),
      .RamAddr (RamAddr),
      .TBRdGnt (TBRdGnt)
   );

endmodule

// File: tb/tb_surv_mem_ctrl.sv
// Directed bench for surv_mem_ctrl with a 16-word RAM, TB_DEPTH=16, TB_STRIDE=8.
module tb_surv_mem_ctrl;

   logic       Clock1 = 1'b0;
   logic       Reset;
   logic       Active;
   logic       SurvValid;
   logic       SurvRDY;
   logic       RamWE;
   logic [3:0] RamAddr;
   logic       TBRdReq;
   logic [3:0] TBRdAddr;
   logic       TBRdGnt;
   logic       TBStart;
   logic [3:0] TBStartAddr;

   int tests_run    = 0;
   int tests_failed = 0;

   surv_mem_ctrl #(
      .WD_RAM_ADDR (4),
      .RAM_DEPTH   (16),
      .TB_DEPTH    (16),
      .TB_STRIDE   (8)
   ) dut (
      .Clock1      (Clock1),
      .Reset       (Reset),
      .Active      (Active),
      .SurvValid   (SurvValid),
      .SurvRDY     (SurvRDY),
      .RamWE       (RamWE),
      .RamAddr     (RamAddr),
      .TBRdReq     (TBRdReq),
      .TBRdAddr    (TBRdAddr),
      .TBRdGnt     (TBRdGnt),
      .TBStart     (TBStart),
      .TBStartAddr (TBStartAddr)
   );

   always #5 Clock1 = ~Clock1;

   task automatic step();
      @(posedge Clock1);
      #1;
   endtask

   task automatic do_reset();
      Reset     = 1'b0;
      Active    = 1'b0;
      SurvValid = 1'b0;
      TBRdReq   = 1'b0;
      TBRdAddr  = 4'h0;
      step();
      step();
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      Reset     = 1'b0;
      Active    = 1'b0;
      SurvValid = 1'b0;
      TBRdReq   = 1'b0;
      TBRdAddr  = 4'h0;
      step();
      @(negedge Clock1);
      tests_run += 6;
      if (SurvRDY !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset SurvRDY got %b expected 0", SurvRDY); end
      if (RamWE !== 1'b0)       begin tests_failed++; $display("[TB] FAIL reset RamWE got %b expected 0", RamWE); end
      if (RamAddr !== 4'h0)     begin tests_failed++; $display("[TB] FAIL reset RamAddr got %h expected 0", RamAddr); end
      if (TBRdGnt !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset TBRdGnt got %b expected 0", TBRdGnt); end
      if (TBStart !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset TBStart got %b expected 0", TBStart); end
      if (TBStartAddr !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset TBStartAddr got %h expected 0", TBStartAddr); end
      step();
      Reset = 1'b1;
   endtask

   // Vector i (from 0) gives SurvRDY on odd i; write k lands in cycle 2k at
   // address (k-1) mod 16; tracebacks follow writes 16, 24 and 32.
   task automatic test_fill_run();
      logic       exp_rdy, exp_we, exp_start;
      logic [3:0] exp_addr, exp_saddr;
      do_reset();
      Active = 1'b1;
      step();
      SurvValid = 1'b1;
      for (int i = 0; i < 70; i++) begin
         exp_rdy   = (i % 2) == 1;
         exp_we    = (i >= 2) && ((i % 2) == 0);
         exp_addr  = 4'((i / 2 - 1) % 16);
         exp_start = (i == 33) || (i == 49) || (i == 65);
         exp_saddr = (i == 49) ? 4'd7 : 4'd15;
         @(negedge Clock1);
         tests_run += 3;
         if (SurvRDY !== exp_rdy) begin tests_failed++; $display("[TB] FAIL fill SurvRDY cyc %0d got %b expected %b", i, SurvRDY, exp_rdy); end
         if (RamWE !== exp_we)    begin tests_failed++; $display("[TB] FAIL fill RamWE cyc %0d got %b expected %b", i, RamWE, exp_we); end
         if (TBStart !== exp_start) begin tests_failed++; $display("[TB] FAIL fill TBStart cyc %0d got %b expected %b", i, TBStart, exp_start); end
         if (exp_we) begin
            tests_run++;
            if (RamAddr !== exp_addr) begin tests_failed++; $display("[TB] FAIL fill RamAddr cyc %0d got %h expected %h", i, RamAddr, exp_addr); end
         end
         if (exp_start) begin
            tests_run++;
            if (TBStartAddr !== exp_saddr) begin tests_failed++; $display("[TB] FAIL fill TBStartAddr cyc %0d got %h expected %h", i, TBStartAddr, exp_saddr); end
         end
         step();
      end
      SurvValid = 1'b0;
      Active    = 1'b0;
      step();
      step();
   endtask

   // With a read held, grants land on odd cycles and writes on even cycles.
   task automatic test_arbitration();
      logic [3:0] exp_addr;
      do_reset();
      Active = 1'b1;
      step();
      SurvValid = 1'b1;
      TBRdReq   = 1'b1;
      TBRdAddr  = 4'hA;
      for (int i = 0; i < 13; i++) begin
         @(negedge Clock1);
         tests_run += 3;
         if (i == 0) begin
            if (TBRdGnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL arb TBRdGnt cyc %0d got %b expected 0", i, TBRdGnt); end
            if (RamWE !== 1'b0)   begin tests_failed++; $display("[TB] FAIL arb RamWE cyc %0d got %b expected 0", i, RamWE); end
            if (RamAddr !== 4'h0) begin tests_failed++; $display("[TB] FAIL arb RamAddr cyc %0d got %h expected 0", i, RamAddr); end
         end else if ((i % 2) == 1) begin
            if (TBRdGnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL arb TBRdGnt cyc %0d got %b expected 1", i, TBRdGnt); end
            if (RamWE !== 1'b0)   begin tests_failed++; $display("[TB] FAIL arb RamWE cyc %0d got %b expected 0", i, RamWE); end
            if (RamAddr !== 4'hA) begin tests_failed++; $display("[TB] FAIL arb RamAddr cyc %0d got %h expected a", i, RamAddr); end
         end else begin
            exp_addr = 4'(i / 2 - 1);
            if (TBRdGnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL arb TBRdGnt cyc %0d got %b expected 0", i, TBRdGnt); end
            if (RamWE !== 1'b1)   begin tests_failed++; $display("[TB] FAIL arb RamWE cyc %0d got %b expected 1", i, RamWE); end
            if (RamAddr !== exp_addr) begin tests_failed++; $display("[TB] FAIL arb RamAddr cyc %0d got %h expected %h", i, RamAddr, exp_addr); end
         end
         step();
      end
      SurvValid = 1'b0;
      TBRdReq   = 1'b0;
      Active    = 1'b0;
      step();
   endtask

   task automatic test_idle_read();
      do_reset();
      TBRdReq  = 1'b1;
      TBRdAddr = 4'h3;
      @(negedge Clock1);
      tests_run++;
      if (TBRdGnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_read early TBRdGnt got %b expected 0", TBRdGnt); end
      step();
      @(negedge Clock1);
      tests_run += 2;
      if (TBRdGnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_read TBRdGnt got %b expected 1", TBRdGnt); end
      if (RamAddr !== 4'h3) begin tests_failed++; $display("[TB] FAIL idle_read RamAddr got %h expected 3", RamAddr); end
      TBRdReq = 1'b0;
      step();
      @(negedge Clock1);
      tests_run++;
      if (TBRdGnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_read release TBRdGnt got %b expected 0", TBRdGnt); end
      step();
   endtask

   task automatic test_reset_midrun();
      do_reset();
      Active = 1'b1;
      step();
      SurvValid = 1'b1;
      for (int i = 0; i < 40; i++) step();
      @(negedge Clock1);
      tests_run += 2;
      if (RamWE !== 1'b1)   begin tests_failed++; $display("[TB] FAIL midrun RamWE got %b expected 1", RamWE); end
      if (RamAddr !== 4'h3) begin tests_failed++; $display("[TB] FAIL midrun RamAddr got %h expected 3", RamAddr); end
      Reset = 1'b0;
      #1;
      tests_run += 5;
      if (SurvRDY !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun_rst SurvRDY got %b expected 0", SurvRDY); end
      if (RamWE !== 1'b0)   begin tests_failed++; $display("[TB] FAIL midrun_rst RamWE got %b expected 0", RamWE); end
      if (RamAddr !== 4'h0) begin tests_failed++; $display("[TB] FAIL midrun_rst RamAddr got %h expected 0", RamAddr); end
      if (TBStart !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrun_rst TBStart got %b expected 0", TBStart); end
      if (TBStartAddr !== 4'h0) begin tests_failed++; $display("[TB] FAIL midrun_rst TBStartAddr got %h expected 0", TBStartAddr); end
      SurvValid = 1'b0;
      step();
      Reset = 1'b1;
      step();
      SurvValid = 1'b1;
      @(negedge Clock1);
      tests_run++;
      if (SurvRDY !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_rst first SurvRDY got %b expected 0", SurvRDY); end
      step();
      @(negedge Clock1);
      tests_run++;
      if (SurvRDY !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_rst second SurvRDY got %b expected 1", SurvRDY); end
      step();
      @(negedge Clock1);
      tests_run += 2;
      if (RamWE !== 1'b1)   begin tests_failed++; $display("[TB] FAIL post_rst RamWE got %b expected 1", RamWE); end
      if (RamAddr !== 4'h0) begin tests_failed++; $display("[TB] FAIL post_rst RamAddr got %h expected 0", RamAddr); end
      SurvValid = 1'b0;
      Active    = 1'b0;
      step();
      step();
   endtask

   // Eleven vectors give five writes plus one unpaired vector, then Active drops.
   task automatic test_flush();
      logic exp_start;
      do_reset();
      Active = 1'b1;
      step();
      SurvValid = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) begin
            @(negedge Clock1);
            tests_run += 3;
            if (SurvRDY !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush odd SurvRDY got %b expected 0", SurvRDY); end
            if (RamWE !== 1'b1)   begin tests_failed++; $display("[TB] FAIL flush RamWE got %b expected 1", RamWE); end
            if (RamAddr !== 4'h4) begin tests_failed++; $display("[TB] FAIL flush RamAddr got %h expected 4", RamAddr); end
         end
         step();
      end
      SurvValid = 1'b0;
      Active    = 1'b0;
      for (int i = 11; i < 16; i++) begin
`ifdef SURV_FLUSH_EN
         exp_start = (i == 12);
`else
         exp_start = 1'b0;
`endif
         @(negedge Clock1);
         tests_run++;
         if (TBStart !== exp_start) begin tests_failed++; $display("[TB] FAIL flush TBStart cyc %0d got %b expected %b", i, TBStart, exp_start); end
         if (exp_start) begin
            tests_run++;
            if (TBStartAddr !== 4'h4) begin tests_failed++; $display("[TB] FAIL flush TBStartAddr got %h expected 4", TBStartAddr); end
         end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_fill_run();
      test_arbitration();
      test_idle_read();
      test_reset_midrun();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
